// File: rtl/sci_rx.sv
// sci_rx: serial command interface receiver.
// Takes the already-synchronized RX line, finds the start bit and takes a
// 3-sample majority vote at mid-bit for every bit. Optional parity and the
// stop bit are checked, and each frame is handed over as a one-cycle rx_valid
// pulse.
module sci_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_sync,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_S0   = CW'(H - 1);
  localparam logic [CW-1:0] C_S1   = CW'(H);
  localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   rx_prev, s0, s1, perr_q;
  logic                   active, start_edge, at_dec, bit_end, maj;

  // The edge cycle itself is bit time 0, so busy has to follow the edge
  // combinationally rather than waiting for the state register.
  assign active     = (state != S_IDLE);
  assign start_edge = rx_prev & ~rx_sync;
  assign at_dec     = active && (cnt == C_DEC);
  assign bit_end    = active && (cnt == C_LAST);
  assign maj        = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
  assign busy       = active | start_edge;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state logic: the stop bit leaves at its decision so there is no dead time.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (start_edge) state_d = S_START;
      S_START:  if (at_dec && maj) state_d = S_IDLE;
                else if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && bit_idx == B_LAST)
                  state_d = PARITY_EN ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (at_dec) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bit timing, mid-bit sampling, data assembly and frame delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev  <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
      perr_q   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      // The start edge cycle counts as cnt=0, so the next cycle is cnt=1.
      if (!active)                           cnt <= start_edge ? CW'(1) : '0;
      else if (state_d == S_IDLE || bit_end) cnt <= '0;
      else                                   cnt <= cnt + 1'b1;
      if (active && cnt == C_S0) s0 <= rx_sync;
      if (active && cnt == C_S1) s1 <= rx_sync;
      if (state == S_START)                 bit_idx <= '0;
      else if (state == S_DATA && bit_end)  bit_idx <= bit_idx + 1'b1;
      if (state == S_DATA && at_dec)   shreg[bit_idx] <= maj;
      if (state == S_PARITY && at_dec) perr_q <= ^shreg ^ maj ^ PARITY_ODD;
      if (state == S_STOP && at_dec) begin
        rx_data  <= shreg;
        rx_ferr  <= ~maj;
        rx_perr  <= PARITY_EN ? perr_q : 1'b0;
        rx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sci_rx.sv
// Directed bench for sci_rx: three receivers (8N1, 8E1, 8O1) share one clock.
// Expected frames go into a scoreboard queue when driven and are checked when
// rx_valid fires.
module tb_sci_rx;
  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int H   = CPB / 2;

  typedef struct packed {
    logic [1:0]    u;
    logic          perr;
    logic          ferr;
    logic [DB-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic [DB-1:0] d [3];
  logic v [3], pe [3], fe [3], bz [3];

  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0;
  int vcnt [3] = '{0, 0, 0};
  int vcyc [3] = '{0, 0, 0};
  logic vbusy [3];
  exp_t sb [$];

  sci_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_n (
    .clk(clk), .rst(rst), .rx_sync(rx0), .rx_data(d[0]), .rx_valid(v[0]),
    .rx_perr(pe[0]), .rx_ferr(fe[0]), .busy(bz[0]));
  sci_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_e (
    .clk(clk), .rst(rst), .rx_sync(rx1), .rx_data(d[1]), .rx_valid(v[1]),
    .rx_perr(pe[1]), .rx_ferr(fe[1]), .busy(bz[1]));
  sci_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_o (
    .clk(clk), .rst(rst), .rx_sync(rx2), .rx_data(d[2]), .rx_valid(v[2]),
    .rx_perr(pe[2]), .rx_ferr(fe[2]), .busy(bz[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int u, input logic b);
    case (u)
      0:       rx0 = b;
      1:       rx1 = b;
      default: rx2 = b;
    endcase
  endtask

  task automatic idle(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      set_rx(u, 1'b1);
    end
  endtask

  // Drive one frame bit-by-bit; glitch_k inverts one cycle at cnt=H of that
  // bit, abort_k returns early (no expectation pushed) inside that bit.
  task automatic send(input int u, input logic [DB-1:0] data, input bit par_en,
                      input bit odd, input logic par_bit, input logic stop_bit,
                      input int glitch_k, input int abort_k);
    logic bits [12];
    int   n;
    exp_t e;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < DB; i++) begin bits[n] = data[i]; n++; end
    if (par_en) begin bits[n] = par_bit; n++; end
    bits[n] = stop_bit; n++;
    if (abort_k < 0) begin
      e.u    = 2'(u);
      e.perr = par_en ? (^data ^ par_bit ^ odd) : 1'b0;
      e.ferr = ~stop_bit;
      e.data = data;
      sb.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < CPB; j++) begin
        @(posedge clk); #1;
        if (k == abort_k && j == 2) return;
        set_rx(u, (k == glitch_k && j == H) ? ~bits[k] : bits[k]);
        if (k == 0 && j == 0) t0 = cyc;
      end
    end
  endtask

  // Scoreboard side: every rx_valid must match the oldest outstanding frame.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (v[u] === 1'b1) begin
        exp_t e;
        vcnt[u]++;
        vcyc[u]  = cyc;
        vbusy[u] = bz[u];
        chk("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("unit", u, e.u);
          chk("rx_data", d[u], e.data);
          chk("rx_perr", pe[u], e.perr);
          chk("rx_ferr", fe[u], e.ferr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", d[0], 0);
    chk("rst_valid", v[0], 0);
    chk("rst_perr", pe[0], 0);
    chk("rst_ferr", fe[0], 0);
    chk("rst_busy", bz[0], 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(0, 5);

    // 8N1 0xA5: valid exactly at T0+154 with busy already low.
    send(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(0, 4);
    chk("a5_vcnt", vcnt[0], 1);
    chk("a5_latency", vcyc[0] - t0, 154);
    chk("a5_busy_at_valid", vbusy[0], 0);

    // 3-cycle low glitch: false start, busy T0..T0+9.
    idle(0, 10);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      rx0 = (i < 3) ? 1'b0 : 1'b1;
      if (i == 0) t0 = cyc;
      @(negedge clk);
      chk($sformatf("glitch_busy_T%0d", i), bz[0], (i <= 9));
    end
    idle(0, 20);
    chk("glitch_no_valid", vcnt[0], 1);

    // Framing error: 0x3C with stop bit 0; line held low gives no new frame.
    send(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    chk("ferr_vcnt", vcnt[0], 2);
    chk("ferr_low_not_busy", bz[0], 0);
    idle(0, 5);
    send(0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(0, 4);
    chk("after_ferr_vcnt", vcnt[0], 3);

    // Parity: even 0x01/p0 -> err, even 0x01/p1 -> ok, odd 0x01/p0 -> ok.
    send(1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(1, 6);
    send(1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
    idle(1, 6);
    send(2, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1);
    idle(2, 6);
    chk("even_vcnt", vcnt[1], 2);
    chk("odd_vcnt", vcnt[2], 1);

    // Back-to-back 0x55 then 0xAA, with a one-cycle mid-bit inversion.
    base = vcnt[0];
    send(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    send(0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 2, -1);
    idle(0, 4);
    chk("b2b_vcnt", vcnt[0] - base, 2);

    // Reset during data bit 4 clears outputs and drops the frame.
    base = vcnt[0];
    send(0, 8'h6B, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5);
    rst = 1'b1;
    #1;
    chk("midrst_data", d[0], 0);
    chk("midrst_valid", v[0], 0);
    chk("midrst_ferr", fe[0], 0);
    chk("midrst_busy", bz[0], 0);
    rx0 = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    chk("low_at_release_busy", bz[0], 0);
    chk("midrst_no_valid", vcnt[0], base);
    idle(0, 4);
    send(0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(0, 4);
    chk("post_rst_vcnt", vcnt[0] - base, 1);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
